uart_wb_bridge: RTL and testbench
=================================

UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5, giving clock cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 30, giving the Wishbone word-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, giving the Wishbone data width; it is a multiple of 8 in 8..64.
REQ-004 SHALL have parameter RX_TIMEOUT, default 65536, giving idle cycles mid-frame before the frame is abandoned.
REQ-005 SHALL have the following ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- uart_rx  in  1  serial input; asynchronous to clk.
- uart_tx  out  1  serial output.
- wb_adr  out  ADDR_WIDTH  word address.
- wb_dat_w  out  DATA_WIDTH  write data.
- wb_dat_r  in  DATA_WIDTH  read data.
- wb_sel  out  DATA_WIDTH/8  byte selects.
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone classic cycle controls.
- wb_ack, wb_err  in  1 each  cycle termination.
- busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-006 uart_rx SHALL pass through a 2-flop synchroniser before any use.
REQ-007 RX SHALL detect a start bit on a synchronised high-to-low transition, sample at mid-bit (CLKS_PER_BIT/2), take 8 data bits LSB first, then check the stop bit.
REQ-008 A received byte with a stop bit of 0 SHALL be discarded and SHALL NOT advance the FSM.
REQ-009 TX SHALL idle high and send start(0), 8 data bits LSB first, then stop(1), each bit held exactly CLKS_PER_BIT cycles.
REQ-010 Frame format SHALL be: CMD byte; LEN byte; 4 address bytes MSB first, of which the low ADDR_WIDTH bits are used; then for writes, LEN words of DATA_WIDTH/8 bytes each, MSB first.
REQ-011 CMD values: 0x01 is write, 0x02 is read; any other CMD byte SHALL be dropped and the FSM SHALL stay IDLE.
REQ-012 FSM states SHALL be IDLE, LEN, ADDR, WDATA, WB_WR, WB_RD, TX_WORD.
REQ-013 State transitions:
- IDLE->LEN on a valid CMD.
- LEN->ADDR.
- ADDR->WDATA (write) or ADDR->WB_RD (read) after the 4th address byte.
- WDATA->WB_WR after the last byte of a word.
- WB_WR->WDATA, or ->IDLE when the word count is exhausted.
- WB_RD->TX_WORD.
- TX_WORD->WB_RD, or ->IDLE after the last word.
REQ-014 LEN=0 SHALL return the FSM to IDLE after the address phase, with no Wishbone cycle and no TX output.
REQ-015 wb_cyc and wb_stb SHALL assert the cycle after entering WB_WR/WB_RD, and SHALL hold until the first cycle where wb_ack or wb_err is high; both SHALL deassert the following cycle.
REQ-016 wb_sel SHALL be all ones during a cycle; wb_we SHALL be 1 only in WB_WR.
REQ-017 wb_adr SHALL increment by 1 per completed word, wrapping modulo 2^ADDR_WIDTH.
REQ-018 In reads, the data latched on ack SHALL be sent MSB byte first; on wb_err the word sent SHALL be all ones; the first start bit SHALL begin the cycle after termination.
REQ-019 The next read cycle SHALL NOT start until the stop bit of the previous word's last byte has completed.
REQ-020 In states LEN, ADDR and WDATA, RX_TIMEOUT cycles without a valid byte SHALL return the FSM to IDLE with no Wishbone cycle.
REQ-021 Bytes received during WB_RD/TX_WORD SHALL be discarded.
REQ-022 A write whose wb_err terminates SHALL continue as if acked.

Reset
REQ-023 On rst high at a clk edge, outputs SHALL be: uart_tx=1, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, wb_sel=0, busy=0; FSM IDLE; RX/TX counters cleared.
REQ-024 Reset mid-cycle or mid-byte SHALL drop the Wishbone cycle and truncate any TX byte, with uart_tx=1 the next cycle.

Verification
REQ-025 Single write with defaults: send 01 01 00 00 24 00 00 00 00 0E -> exactly one WB write, adr=0x2400, dat_w=0x0000000E, sel=0xF.
REQ-026 Burst read: send 02 03 04 00 00 00 with slave returning adr+0x100 -> adr 0x04000000..02 issued in order; TX bytes 04 00 01 00, 04 00 01 01, 04 00 01 02.
REQ-027 Error/garbage: CMD 0x55, then a byte with stop bit 0, then a valid write frame -> only the valid write occurs; wb_err on a read returns FF FF FF FF.
REQ-028 Timeout: send 01 01 00 then stop for RX_TIMEOUT+10 cycles, then a full valid write frame -> busy drops after RX_TIMEOUT; only the second frame writes.
REQ-029 Wrap and width: ADDR_WIDTH=4, DATA_WIDTH=16, write LEN=2 at 0x0F with data 12 34 56 78 -> writes adr 0xF dat 0x1234, then adr 0x0 dat 0x5678.
REQ-030 Reset during TX_WORD mid-byte -> uart_tx=1 and busy=0 the next cycle; a subsequent read frame completes correctly.

Source files
------------

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone bridge: serial command frames become classic
// Wishbone single-word writes/reads; read data returns over TX.
module uart_wb_bridge #(
  parameter int CLKS_PER_BIT = 5,
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int RX_TIMEOUT   = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  output logic                    uart_tx,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]   wb_dat_w,
  input  logic [DATA_WIDTH-1:0]   wb_dat_r,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  output logic                    busy
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ADDR, S_WDATA,
    S_WB_WR, S_WB_RD, S_TX_WORD
  } state_t;

  state_t state, state_nx;

  logic rx_s1, rx_s2, rx_prev;
  logic rx_act, rx_valid;
  logic [15:0] rx_cnt;
  logic [3:0] rx_idx;
  logic [7:0] rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // idx 0 = start check, 1..8 = data, 9 = stop
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_act   <= 1'b0;
      rx_valid <= 1'b0;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_s2) begin
          rx_act <= 1'b1;
          rx_cnt <= 16'(HALF - 1);
          rx_idx <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= 16'(CLKS_PER_BIT - 1);
        rx_idx <= rx_idx + 4'd1;
        if (rx_idx == 4'd0) begin
          if (rx_s2) rx_act <= 1'b0;
        end else if (rx_idx == 4'd9) begin
          rx_act   <= 1'b0;
          rx_valid <= rx_s2;
        end else begin
          rx_sh <= {rx_s2, rx_sh[7:1]};
        end
      end
    end
  end

  logic tx_busy, tx_start;
  logic [7:0] tx_byte;
  logic [9:0] tx_sh;
  logic [15:0] tx_cnt;
  logic [3:0] tx_nb;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_nb   <= '0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, tx_byte, 1'b0};
      tx_cnt  <= 16'(CLKS_PER_BIT - 1);
      tx_nb   <= 4'd9;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else if (tx_nb == 4'd0) begin
        tx_busy <= 1'b0;
      end else begin
        tx_sh  <= {1'b1, tx_sh[9:1]};
        tx_nb  <= tx_nb - 4'd1;
        tx_cnt <= 16'(CLKS_PER_BIT - 1);
      end
    end
  end

  assign uart_tx = tx_busy ? tx_sh[0] : 1'b1;

  logic is_wr, term, timeout;
  logic [7:0] len_left;
  logic [3:0] byte_cnt, tx_left;
  logic [31:0] to_cnt;
  logic [DATA_WIDTH-1:0] rd_word, rd_in;

  assign term    = wb_cyc && (wb_ack || wb_err);
  assign rd_in   = wb_err ? '1 : wb_dat_r;
  assign timeout = !rx_valid && (to_cnt == 32'(RX_TIMEOUT - 1));
  assign busy    = (state != S_IDLE);
  assign wb_stb  = wb_cyc;
  assign wb_sel  = {NB{wb_cyc}};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    tx_byte  = rd_word[DATA_WIDTH-1 -: 8];
    unique case (state)
      S_IDLE:
        if (rx_valid && (rx_sh == 8'h01 || rx_sh == 8'h02))
          state_nx = S_LEN;
      S_LEN:
        if (rx_valid)     state_nx = S_ADDR;
        else if (timeout) state_nx = S_IDLE;
      S_ADDR:
        if (rx_valid && byte_cnt == 4'd3) begin
          if (len_left == 8'd0) state_nx = S_IDLE;
          else if (is_wr)       state_nx = S_WDATA;
          else                  state_nx = S_WB_RD;
        end else if (timeout) begin
          state_nx = S_IDLE;
        end
      S_WDATA:
        if (rx_valid && byte_cnt == 4'(NB - 1)) state_nx = S_WB_WR;
        else if (timeout)                       state_nx = S_IDLE;
      S_WB_WR:
        if (term) state_nx = (len_left == 8'd1) ? S_IDLE : S_WDATA;
      S_WB_RD:
        if (term) begin
          state_nx = S_TX_WORD;
          tx_start = 1'b1;
          tx_byte  = rd_in[DATA_WIDTH-1 -: 8];
        end
      S_TX_WORD:
        if (!tx_busy) begin
          if (tx_left != 4'd0)       tx_start = 1'b1;
          else if (len_left == 8'd0) state_nx = S_IDLE;
          else                       state_nx = S_WB_RD;
        end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_adr   <= '0;
      wb_dat_w <= '0;
      wb_cyc   <= 1'b0;
      wb_we    <= 1'b0;
      is_wr    <= 1'b0;
      len_left <= '0;
      byte_cnt <= '0;
      tx_left  <= '0;
      to_cnt   <= '0;
      rd_word  <= '0;
    end else begin
      if (state inside {S_LEN, S_ADDR, S_WDATA} && !rx_valid)
        to_cnt <= to_cnt + 32'd1;
      else
        to_cnt <= '0;
      unique case (state)
        S_IDLE: begin
          byte_cnt <= '0;
          if (rx_valid) is_wr <= (rx_sh == 8'h01);
        end
        S_LEN:
          if (rx_valid) len_left <= rx_sh;
        S_ADDR:
          if (rx_valid) begin
            wb_adr   <= ADDR_WIDTH'({wb_adr, rx_sh});
            byte_cnt <= (byte_cnt == 4'd3) ? 4'd0 : byte_cnt + 4'd1;
          end
        S_WDATA:
          if (rx_valid) begin
            wb_dat_w <= DATA_WIDTH'({wb_dat_w, rx_sh});
            byte_cnt <= (byte_cnt == 4'(NB - 1)) ? 4'd0 : byte_cnt + 4'd1;
          end
        S_WB_WR, S_WB_RD:
          if (!wb_cyc) begin
            wb_cyc <= 1'b1;
            wb_we  <= (state == S_WB_WR);
          end else if (wb_ack || wb_err) begin
            wb_cyc   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= wb_adr + ADDR_WIDTH'(1);
            len_left <= len_left - 8'd1;
            if (state == S_WB_RD) begin
              rd_word <= rd_in << 8;
              tx_left <= 4'(NB - 1);
            end
          end
        S_TX_WORD:
          if (tx_start) begin
            rd_word <= rd_word << 8;
            tx_left <= tx_left - 4'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: UART frames in, Wishbone
// transactions and TX bytes checked against hand-computed values.
module tb_uart_wb_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        rx0 = 1'b1, tx0;
  logic [29:0] adr0;
  logic [31:0] dw0, dr0;
  logic [3:0]  sel0;
  logic        cyc0, stb0, we0, busy0;
  logic        ack0 = 1'b0, err0 = 1'b0;
  logic        err_mode = 1'b0;

  logic        rx1 = 1'b1, tx1;
  logic [3:0]  adr1;
  logic [15:0] dw1, dr1;
  logic [1:0]  sel1;
  logic        cyc1, stb1, we1, busy1, err1;
  logic        ack1 = 1'b0;

  assign dr0  = {2'b00, adr0} + 32'h100;
  assign dr1  = 16'h0;
  assign err1 = 1'b0;

  uart_wb_bridge #(.RX_TIMEOUT(1000)) u0 (
    .clk(clk), .rst(rst), .uart_rx(rx0), .uart_tx(tx0),
    .wb_adr(adr0), .wb_dat_w(dw0), .wb_dat_r(dr0), .wb_sel(sel0),
    .wb_cyc(cyc0), .wb_stb(stb0), .wb_we(we0),
    .wb_ack(ack0), .wb_err(err0), .busy(busy0)
  );

  uart_wb_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .uart_rx(rx1), .uart_tx(tx1),
    .wb_adr(adr1), .wb_dat_w(dw1), .wb_dat_r(dr1), .wb_sel(sel1),
    .wb_cyc(cyc1), .wb_stb(stb1), .wb_we(we1),
    .wb_ack(ack1), .wb_err(err1), .busy(busy1)
  );

  // slave models: terminate one cycle after cyc/stb seen
  always @(posedge clk) begin
    ack0 <= 1'b0;
    err0 <= 1'b0;
    if (cyc0 && stb0 && !ack0 && !err0) begin
      if (err_mode) err0 <= 1'b1;
      else          ack0 <= 1'b1;
    end
    ack1 <= cyc1 && stb1 && !ack1;
  end

  logic [29:0] la0[$];
  logic [31:0] ld0[$];
  logic        lw0[$];
  time         tt0[$];
  int          sel_bad0 = 0;
  logic [3:0]  la1[$];
  logic [15:0] ld1[$];
  logic        lw1[$];

  always @(posedge clk) begin
    if (cyc0 && stb0 && (ack0 || err0)) begin
      la0.push_back(adr0);
      ld0.push_back(dw0);
      lw0.push_back(we0);
      tt0.push_back($time);
      if (sel0 !== 4'hF) sel_bad0++;
    end
    if (cyc1 && stb1 && ack1) begin
      la1.push_back(adr1);
      ld1.push_back(dw1);
      lw1.push_back(we1);
    end
  end

  logic [7:0] txq[$];
  time        txt[$];

  always begin : mon
    logic [7:0] b;
    time t0;
    @(negedge tx0);
    t0 = $time;
    repeat (2) @(posedge clk);
    #1;
    if (tx0 === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (5) @(posedge clk);
        #1;
        b[i] = tx0;
      end
      repeat (5) @(posedge clk);
      #1;
      txq.push_back(b);
      txt.push_back(t0);
    end
  end

  logic [7:0] frm[$];

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int w, input logic v);
    if (w == 0) rx0 = v;
    else        rx1 = v;
  endtask

  task automatic send_byte(input int w, input logic [7:0] b,
                           input logic sb);
    set_rx(w, 1'b0);
    wait_cycles(5);
    for (int i = 0; i < 8; i++) begin
      set_rx(w, b[i]);
      wait_cycles(5);
    end
    set_rx(w, sb);
    wait_cycles(5);
    set_rx(w, 1'b1);
    if (!sb) wait_cycles(5);
  endtask

  task automatic send_frame(input int w);
    foreach (frm[i]) send_byte(w, frm[i], 1'b1);
  endtask

  task automatic clear_logs();
    la0.delete(); ld0.delete(); lw0.delete(); tt0.delete();
    txq.delete(); txt.delete();
    sel_bad0 = 0;
  endtask

  task automatic wait_tx(input int n, input string nm);
    int k;
    for (k = 0; k < 4000 && txq.size() < n; k++) @(posedge clk);
    #1;
    checks++;
    if (txq.size() < n) begin
      failures++;
      $display("FAIL %s_tx_timeout got=%0d bytes exp=%0d", nm, txq.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx0); end
    checks++; if (cyc0 !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%b exp=0", cyc0); end
    checks++; if (stb0 !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", stb0); end
    checks++; if (we0 !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", we0); end
    checks++; if (adr0 !== 30'h0) begin failures++; $display("FAIL reset_adr got=%h exp=0", adr0); end
    checks++; if (dw0 !== 32'h0) begin failures++; $display("FAIL reset_dat_w got=%h exp=0", dw0); end
    checks++; if (sel0 !== 4'h0) begin failures++; $display("FAIL reset_sel got=%h exp=0", sel0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_single_write();
    clear_logs();
    frm = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h24, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h0E};
    send_frame(0);
    wait_cycles(20);
    checks++; if (la0.size() != 1) begin failures++; $display("FAIL wr_count got=%0d exp=1", la0.size()); end
    if (la0.size() >= 1) begin
      checks++; if (la0[0] !== 30'h2400) begin failures++; $display("FAIL wr_adr got=%h exp=2400", la0[0]); end
      checks++; if (ld0[0] !== 32'h0000000E) begin failures++; $display("FAIL wr_dat got=%h exp=0000000e", ld0[0]); end
      checks++; if (lw0[0] !== 1'b1) begin failures++; $display("FAIL wr_we got=%b exp=1", lw0[0]); end
    end
    checks++; if (sel_bad0 != 0) begin failures++; $display("FAIL wr_sel bad=%0d exp=0", sel_bad0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL wr_busy got=%b exp=0", busy0); end
    checks++; if (txq.size() != 0) begin failures++; $display("FAIL wr_no_tx got=%0d exp=0", txq.size()); end
  endtask

  task automatic test_burst_read();
    logic [7:0] exp_b [12];
    exp_b = '{8'h04, 8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 8'h01, 8'h01,
              8'h04, 8'h00, 8'h01, 8'h02};
    clear_logs();
    frm = '{8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    wait_tx(12, "burst");
    wait_cycles(10);
    checks++; if (la0.size() != 3) begin failures++; $display("FAIL rd_count got=%0d exp=3", la0.size()); end
    for (int i = 0; i < 3 && i < la0.size(); i++) begin
      checks++;
      if (la0[i] !== 30'h4000000 + 30'(i) || lw0[i] !== 1'b0) begin
        failures++;
        $display("FAIL rd_adr%0d got=%h we=%b exp=%h we=0", i, la0[i], lw0[i], 30'h4000000 + 30'(i));
      end
    end
    for (int i = 0; i < 12 && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== exp_b[i]) begin failures++; $display("FAIL rd_byte%0d got=%h exp=%h", i, txq[i], exp_b[i]); end
    end
    if (txt.size() >= 4 && tt0.size() >= 2) begin
      checks++;
      if (txt[0] != tt0[0]) begin failures++; $display("FAIL rd_first_start got=%0t exp=%0t", txt[0], tt0[0]); end
      checks++;
      if (tt0[1] < txt[3] + 500) begin failures++; $display("FAIL rd_next_cycle got=%0t exp>=%0t", tt0[1], txt[3] + 500); end
    end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rd_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_garbage();
    clear_logs();
    send_byte(0, 8'h55, 1'b1);
    wait_cycles(5);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL bad_cmd_busy got=%b exp=0", busy0); end
    send_byte(0, 8'h01, 1'b0);
    wait_cycles(5);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL bad_stop_busy got=%b exp=0", busy0); end
    frm = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10,
            8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(0);
    wait_cycles(20);
    checks++; if (la0.size() != 1) begin failures++; $display("FAIL garb_count got=%0d exp=1", la0.size()); end
    if (la0.size() >= 1) begin
      checks++;
      if (la0[0] !== 30'h10 || ld0[0] !== 32'h11223344) begin
        failures++;
        $display("FAIL garb_write got=%h/%h exp=10/11223344", la0[0], ld0[0]);
      end
    end
  endtask

  task automatic test_err();
    clear_logs();
    err_mode = 1'b1;
    frm = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
    send_frame(0);
    wait_tx(4, "err_rd");
    wait_cycles(10);
    for (int i = 0; i < 4 && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== 8'hFF) begin failures++; $display("FAIL err_byte%0d got=%h exp=ff", i, txq[i]); end
    end
    clear_logs();
    frm = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h30,
            8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    send_frame(0);
    wait_cycles(20);
    err_mode = 1'b0;
    checks++; if (la0.size() != 2) begin failures++; $display("FAIL err_wr_count got=%0d exp=2", la0.size()); end
    if (la0.size() >= 2) begin
      checks++;
      if (la0[1] !== 30'h31 || ld0[1] !== 32'hB1B2B3B4) begin
        failures++;
        $display("FAIL err_wr_second got=%h/%h exp=31/b1b2b3b4", la0[1], ld0[1]);
      end
    end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL err_wr_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_timeout();
    clear_logs();
    frm = '{8'h01, 8'h01, 8'h00};
    send_frame(0);
    wait_cycles(990);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL to_busy_hold got=%b exp=1", busy0); end
    wait_cycles(20);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL to_busy_drop got=%b exp=0", busy0); end
    frm = '{8'h01, 8'h01, 8'hC0, 8'h00, 8'h12, 8'h34,
            8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_frame(0);
    wait_cycles(20);
    checks++; if (la0.size() != 1) begin failures++; $display("FAIL to_count got=%0d exp=1", la0.size()); end
    if (la0.size() >= 1) begin
      checks++;
      if (la0[0] !== 30'h1234 || ld0[0] !== 32'hCAFEBABE) begin
        failures++;
        $display("FAIL to_write got=%h/%h exp=1234/cafebabe", la0[0], ld0[0]);
      end
    end
  endtask

  task automatic test_len_zero();
    clear_logs();
    frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h50};
    send_frame(0);
    wait_cycles(100);
    checks++; if (la0.size() != 0) begin failures++; $display("FAIL len0_wb got=%0d exp=0", la0.size()); end
    checks++; if (txq.size() != 0) begin failures++; $display("FAIL len0_tx got=%0d exp=0", txq.size()); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL len0_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_reset_tx();
    logic [7:0] exp_b [4];
    int k;
    exp_b = '{8'h00, 8'h00, 8'h01, 8'h40};
    clear_logs();
    frm = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h30};
    send_frame(0);
    for (k = 0; k < 200 && tx0 !== 1'b0; k++) wait_cycles(1);
    wait_cycles(12);
    checks++; if (tx0 !== 1'b0) begin failures++; $display("FAIL rst_tx_mid got=%b exp=0", tx0); end
    rst = 1'b1;
    wait_cycles(1);
    checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL rst_tx_idle got=%b exp=1", tx0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_tx_busy got=%b exp=0", busy0); end
    rst = 1'b0;
    wait_cycles(100);
    clear_logs();
    frm = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40};
    send_frame(0);
    wait_tx(4, "post_rst");
    for (int i = 0; i < 4 && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== exp_b[i]) begin failures++; $display("FAIL post_rst_byte%0d got=%h exp=%h", i, txq[i], exp_b[i]); end
    end
    checks++; if (la0.size() != 1) begin failures++; $display("FAIL post_rst_count got=%0d exp=1", la0.size()); end
  endtask

  task automatic test_wrap();
    la1.delete(); ld1.delete(); lw1.delete();
    frm = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h0F,
            8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(1);
    wait_cycles(20);
    checks++; if (la1.size() != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", la1.size()); end
    if (la1.size() >= 2) begin
      checks++;
      if (la1[0] !== 4'hF || ld1[0] !== 16'h1234 || lw1[0] !== 1'b1) begin
        failures++;
        $display("FAIL wrap_w0 got=%h/%h exp=f/1234", la1[0], ld1[0]);
      end
      checks++;
      if (la1[1] !== 4'h0 || ld1[1] !== 16'h5678 || lw1[1] !== 1'b1) begin
        failures++;
        $display("FAIL wrap_w1 got=%h/%h exp=0/5678", la1[1], ld1[1]);
      end
    end
    checks++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL wrap_idle tx=%b busy=%b exp=1/0", tx1, busy1); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_burst_read();
    test_garbage();
    test_err();
    test_timeout();
    test_len_zero();
    test_reset_tx();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
